adder4_frame_accum: RTL and testbench
=====================================

# adder4_frame_accum

Downstream consumer of the 4-bit full-adder stage. It accepts each adder result, `{cout, sum}`, as a 5-bit sample through a valid/ready handshake. It accumulates a frame of samples into a wide total and presents the frame result through a second valid/ready handshake. It turns the combinational adder into a measurable datapath for board-level checks.

## Interface
- `ACC_W`, default 12: accumulator and result width, legal range 6..16.
- `FRAME_LEN`, default 8: samples per frame, legal range 1..255.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: the sample on `in_sum`/`in_cout` is valid.
- `in_ready` out 1: the block can accept a sample this cycle.
- `in_sum` in 4: adder sum bits.
- `in_cout` in 1: adder carry-out; the sample value is `{in_cout,in_sum}`, range 0..31.
- `flush` in 1: close the current frame early.
- `out_valid` out 1: frame result is valid.
- `out_ready` in 1: the consumer takes the result this cycle.
- `out_total` out ACC_W: frame sum.
- `out_count` out 8: number of samples in the frame.
- `out_ovf` out 1: the total exceeded `2^ACC_W-1` at some point in the frame.

## Operation
- An accept occurs when `in_valid && in_ready`. An output handshake occurs when `out_valid && out_ready`.
- The FSM has three states: IDLE, ACC and HOLD.
  - `in_ready` = 1 in IDLE and ACC, and 0 in HOLD.
  - `out_valid` = 1 only in HOLD.
- IDLE:
  - On accept: acc = sample, count = 1, ovf = 0.
  - Next state is HOLD if FRAME_LEN==1 or `flush`=1; otherwise ACC.
  - `flush` without an accept is ignored (no empty frames).
- ACC:
  - On accept: acc = acc + sample, count = count + 1.
  - Go to HOLD when the new count equals FRAME_LEN, or when `flush`=1.
  - `flush` without an accept also goes to HOLD, keeping the current acc/count (count ≥ 1 is guaranteed).
  - Accept together with `flush`: the sample is included, then the frame closes.
- HOLD:
  - `out_total`/`out_count`/`out_ovf` are held stable until the output handshake; inputs are ignored.
  - On the output handshake, go to IDLE.
- Arithmetic: the sample is zero-extended to ACC_W+1 bits and added to acc.
  - If the carry out of bit ACC_W-1 is set, ovf becomes 1 (sticky for the frame).
  - By default the result wraps modulo `2^ACC_W`.
- Reset at any point: discard the partial frame and return to IDLE.
  - Reset values: acc=0, count=0, ovf=0.
  - Output reset values: `out_valid`=0, `in_ready`=1 (IDLE), `out_total`=0, `out_count`=0, `out_ovf`=0.

## Timing
- All outputs are registered. `in_ready` and `out_valid` are decoded directly from the state register.
- Latency: `out_valid` rises on the clock edge that accepts the final sample, or on the `flush` edge. The result is visible one cycle after that input cycle.
- After the output handshake edge, `out_valid`=0 and `in_ready`=1 in the next cycle.
- Minimum period per frame is FRAME_LEN + 1 cycles, because of the one dead input cycle in HOLD.
- `out_*` must not change while `out_valid`=1 and `out_ready`=0.
- `out_count` wraps nowhere: FRAME_LEN ≤ 255.

## Configuration
- `ADDER4_ACCUM_SAT_EN` defined: on overflow, acc clamps to `2^ACC_W-1` and stays there for the rest of the frame. ovf is still set.
- Undefined: the accumulator wraps modulo `2^ACC_W`, and ovf is set.
- Handshake, state and timing behaviour are identical in both builds.

## Structure
- Shared package `adder4_accum_pkg`:
  - state enum IDLE/ACC/HOLD;
  - `SAMPLE_W`=5;
  - `CNT_W`=8;
  - a function returning the next acc and overflow flag (wrap or saturate is selected by the macro).
- One sub-module, `accum_sat_add`: a registered-free ACC_W-bit adder with the 5-bit zero-extended operand, producing the sum and overflow. The top level holds the FSM, the counters and the output registers.

## Test plan
- FRAME_LEN=4, ACC_W=12, samples 5, 10, 15, 31 (`in_sum`=15, `in_cout`=1) -> `out_total`=61, `out_count`=4, `out_ovf`=0. `out_valid` is 1 one cycle after the 4th accept.
- ACC_W=6, FRAME_LEN=3, samples 31, 31, 31:
  - without the macro -> `out_total`=29, `out_ovf`=1;
  - with `ADDER4_ACCUM_SAT_EN` -> `out_total`=63, `out_ovf`=1.
- FRAME_LEN=8, samples 3, 4, with `flush` asserted on the cycle of the 4 -> `out_total`=7, `out_count`=2. `flush` alone in IDLE -> `out_valid` stays 0.
- Output backpressure: `out_ready`=0 for 5 cycles in HOLD while `in_valid`=1 -> `out_valid`=1, `in_ready`=0, outputs stable. On `out_ready`=1, IDLE follows next cycle.
- `rst` for one cycle after 2 of 4 samples -> next cycle `out_valid`=0 and `in_ready`=1. A following frame of 1, 1, 1, 1 -> `out_total`=4.
- FRAME_LEN=1, sample 17 -> `out_total`=17, `out_count`=1. Back-to-back frames with `out_ready` held at 1 -> a new result every 2 cycles.

Source files
------------

// File: rtl/adder4_accum_pkg.sv
// Shared types and helpers for the adder4 frame accumulator.
// Build macro ADDER4_ACCUM_SAT_EN selects saturating instead of wrapping accumulation.
package adder4_accum_pkg;

    localparam int unsigned SAMPLE_W = 5;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // clamp=1 means the next acc is forced to all-ones instead of the wrapped sum
    typedef struct packed {
        logic ovf;
        logic clamp;
    } acc_ctl_t;

    function automatic acc_ctl_t acc_next_ctl(input logic carry, input logic ovf_prev);
        acc_ctl_t ctl;
        ctl.ovf = ovf_prev | carry;
`ifdef ADDER4_ACCUM_SAT_EN
        ctl.clamp = ctl.ovf;
`else
        ctl.clamp = 1'b0;
`endif
        return ctl;
    endfunction

endpackage

// File: rtl/adder4_frame_accum_sat_add.sv
// accum_sat_add: combinational ACC_W-bit accumulate step with a zero-extended 5-bit sample.
// Wrap or saturate on overflow is chosen by ADDER4_ACCUM_SAT_EN through the package helper.
module accum_sat_add
    import adder4_accum_pkg::*;
#(
    parameter int unsigned ACC_W = 12
) (
    input  logic [ACC_W-1:0]    acc_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                ovf_i,
    output logic [ACC_W-1:0]    sum_o,
    output logic                ovf_o
);

    logic [ACC_W:0] raw;
    acc_ctl_t       ctl;

    always_comb begin
        raw   = {1'b0, acc_i} + (ACC_W+1)'(sample_i);
        ctl   = acc_next_ctl(raw[ACC_W], ovf_i);
        sum_o = ctl.clamp ? '1 : raw[ACC_W-1:0];
        ovf_o = ctl.ovf;
    end

endmodule

// File: rtl/adder4_frame_accum.sv
// adder4_frame_accum: sums frames of {cout,sum} adder samples and hands out one result per frame.
// ADDER4_ACCUM_SAT_EN (see package) switches the accumulator from wrapping to saturating.
module adder4_frame_accum
    import adder4_accum_pkg::*;
#(
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_cout,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, add_base, add_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d, ovf_base, add_ovf;
    logic             accept, last;

    assign accept = in_valid && in_ready;

    // A new frame starts from zero, so IDLE feeds the adder a cleared base and flag
    assign add_base = (state_q == ST_IDLE) ? '0 : acc_q;
    assign ovf_base = (state_q == ST_ACC) && ovf_q;
    assign cnt_inc  = ((state_q == ST_IDLE) ? '0 : cnt_q) + CNT_W'(1);
    assign last     = (cnt_inc == CNT_W'(FRAME_LEN));

    accum_sat_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .acc_i   (add_base),
        .sample_i({in_cout, in_sum}),
        .ovf_i   (ovf_base),
        .sum_o   (add_sum),
        .ovf_o   (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (accept) begin
                    acc_d   = add_sum;
                    cnt_d   = cnt_inc;
                    ovf_d   = add_ovf;
                    state_d = (last || flush) ? ST_HOLD : ST_ACC;
                end else if (flush && state_q == ST_ACC) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign out_total = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder4_frame_accum.sv
// Scoreboard bench for adder4_frame_accum: four instances cover the frame-length and width cases.
`timescale 1ns/1ps
module tb_adder4_frame_accum;

`ifdef ADDER4_ACCUM_SAT_EN
    localparam int B_EXP = 63;
`else
    localparam int B_EXP = 29;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [4], in_valid [4], in_cout [4], flush [4], out_ready [4];
    logic [3:0] in_sum [4];

    logic        rdy0, rdy1, rdy2, rdy3, ov0, ov1, ov2, ov3, of0, of1, of2, of3;
    logic [11:0] tot0, tot2, tot3;
    logic [5:0]  tot1;
    logic [7:0]  cnt0, cnt1, cnt2, cnt3;

    logic        rdy [4], ovld [4], ovf [4];
    logic [11:0] tot [4];
    logic [7:0]  cnt [4];

    always_comb begin
        rdy[0] = rdy0; rdy[1] = rdy1; rdy[2] = rdy2; rdy[3] = rdy3;
        ovld[0] = ov0; ovld[1] = ov1; ovld[2] = ov2; ovld[3] = ov3;
        ovf[0] = of0; ovf[1] = of1; ovf[2] = of2; ovf[3] = of3;
        tot[0] = tot0; tot[1] = {6'b0, tot1}; tot[2] = tot2; tot[3] = tot3;
        cnt[0] = cnt0; cnt[1] = cnt1; cnt[2] = cnt2; cnt[3] = cnt3;
    end

    adder4_frame_accum #(.ACC_W(12), .FRAME_LEN(4)) u_a (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(rdy0), .in_sum(in_sum[0]),
        .in_cout(in_cout[0]), .flush(flush[0]), .out_valid(ov0), .out_ready(out_ready[0]),
        .out_total(tot0), .out_count(cnt0), .out_ovf(of0));
    adder4_frame_accum #(.ACC_W(6), .FRAME_LEN(3)) u_b (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(rdy1), .in_sum(in_sum[1]),
        .in_cout(in_cout[1]), .flush(flush[1]), .out_valid(ov1), .out_ready(out_ready[1]),
        .out_total(tot1), .out_count(cnt1), .out_ovf(of1));
    adder4_frame_accum #(.ACC_W(12), .FRAME_LEN(8)) u_c (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(rdy2), .in_sum(in_sum[2]),
        .in_cout(in_cout[2]), .flush(flush[2]), .out_valid(ov2), .out_ready(out_ready[2]),
        .out_total(tot2), .out_count(cnt2), .out_ovf(of2));
    adder4_frame_accum #(.ACC_W(12), .FRAME_LEN(1)) u_d (
        .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(rdy3), .in_sum(in_sum[3]),
        .in_cout(in_cout[3]), .flush(flush[3]), .out_valid(ov3), .out_ready(out_ready[3]),
        .out_total(tot3), .out_count(cnt3), .out_ovf(of3));

    typedef struct {
        int id;
        int total;
        int count;
        int ovf;
    } exp_t;

    exp_t sb [$];
    int   total_n = 0;
    int   bad_n   = 0;

    task automatic chk(string name, int act, int req);
        total_n++;
        if (act != req) begin
            bad_n++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every output handshake retires the oldest expected frame result
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ovld[i] && out_ready[i]) begin
                exp_t e;
                if (sb.size() == 0) begin
                    total_n++;
                    bad_n++;
                    $display("FAIL unexpected_result dut=%0d actual=%0d required=none", i, tot[i]);
                end else begin
                    e = sb.pop_front();
                    chk("sb_dut", i, e.id);
                    chk("sb_total", int'(tot[i]), e.total);
                    chk("sb_count", int'(cnt[i]), e.count);
                    chk("sb_ovf", int'(ovf[i]), e.ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int i, int v, bit fl);
        int n;
        n = 0;
        while (!rdy[i] && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_wait", int'(rdy[i]), 1);
        in_valid[i] = 1'b1;
        in_sum[i]   = v[3:0];
        in_cout[i]  = v[4];
        flush[i]    = fl;
        tick();
        in_valid[i] = 1'b0;
        flush[i]    = 1'b0;
    endtask

    task automatic drain(int i);
        int n;
        n = 0;
        while (!ovld[i] && n < 20) begin
            tick();
            n++;
        end
        chk("out_valid_wait", int'(ovld[i]), 1);
        out_ready[i] = 1'b1;
        tick();
        out_ready[i] = 1'b0;
        chk("post_hs_valid", int'(ovld[i]), 0);
        chk("post_hs_ready", int'(rdy[i]), 1);
    endtask

    initial begin
        int d_s [3];
        d_s = '{17, 2, 31};
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1; in_valid[i] = 1'b0; in_cout[i] = 1'b0;
            flush[i] = 1'b0; out_ready[i] = 1'b0; in_sum[i] = 4'd0;
        end
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rst_out_valid", int'(ovld[i]), 0);
            chk("rst_in_ready", int'(rdy[i]), 1);
            chk("rst_total", int'(tot[i]), 0);
            chk("rst_count", int'(cnt[i]), 0);
            chk("rst_ovf", int'(ovf[i]), 0);
            rst[i] = 1'b0;
        end

        // Basic frame then output backpressure with inputs still offered
        sb.push_back('{0, 61, 4, 0});
        send(0, 5, 0); send(0, 10, 0); send(0, 15, 0);
        chk("pre_last_valid", int'(ovld[0]), 0);
        send(0, 31, 0);
        chk("latency_valid", int'(ovld[0]), 1);
        chk("hold_ready", int'(rdy[0]), 0);
        in_valid[0] = 1'b1; in_sum[0] = 4'd7; in_cout[0] = 1'b0;
        repeat (5) begin
            tick();
            chk("bp_valid", int'(ovld[0]), 1);
            chk("bp_ready", int'(rdy[0]), 0);
            chk("bp_total", int'(tot[0]), 61);
            chk("bp_count", int'(cnt[0]), 4);
        end
        in_valid[0] = 1'b0;
        drain(0);

        // Reset mid-frame, then a clean frame
        send(0, 1, 0); send(0, 2, 0);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("midrst_valid", int'(ovld[0]), 0);
        chk("midrst_ready", int'(rdy[0]), 1);
        chk("midrst_count", int'(cnt[0]), 0);
        sb.push_back('{0, 4, 4, 0});
        repeat (4) send(0, 1, 0);
        drain(0);

        // Overflow in a 6-bit accumulator
        sb.push_back('{1, B_EXP, 3, 1});
        repeat (3) send(1, 31, 0);
        drain(1);

        // Flush: ignored in IDLE, closes with an accept, closes alone in ACC
        flush[2] = 1'b1;
        repeat (3) begin
            tick();
            chk("flush_idle_valid", int'(ovld[2]), 0);
        end
        flush[2] = 1'b0;
        chk("flush_idle_count", int'(cnt[2]), 0);
        sb.push_back('{2, 7, 2, 0});
        send(2, 3, 0); send(2, 4, 1);
        chk("flush_accept_valid", int'(ovld[2]), 1);
        drain(2);
        sb.push_back('{2, 9, 1, 0});
        send(2, 9, 0);
        chk("acc_open_valid", int'(ovld[2]), 0);
        flush[2] = 1'b1;
        tick();
        flush[2] = 1'b0;
        chk("flush_alone_valid", int'(ovld[2]), 1);
        drain(2);

        // Single-sample frames back to back with out_ready held
        out_ready[3] = 1'b1;
        in_valid[3]  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{3, d_s[k], 1, 0});
            in_sum[3]  = d_s[k][3:0];
            in_cout[3] = d_s[k][4];
            tick();
            chk("b2b_valid", int'(ovld[3]), 1);
            chk("b2b_total", int'(tot[3]), d_s[k]);
            tick();
            chk("b2b_idle", int'(ovld[3]), 0);
        end
        in_valid[3]  = 1'b0;
        out_ready[3] = 1'b0;

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
